// File: rtl/busarb_pkg.sv
// Shared encodings for the two-master bus arbiter: state values and master IDs.
package busarb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t OWN0 = 2'b01;
  localparam state_t OWN1 = 2'b10;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  // One-hot owner indication for a given state; non-owning states read as idle.
  function automatic logic [1:0] gnt_of(input state_t st);
    logic [1:0] g;
    g = '0;
    case (st)
      OWN0:    g = 2'b01;
      OWN1:    g = 2'b10;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/busarb.sv
// Two-master (CPU/DMA) bus arbiter: alternating priority on ties, one owner at a
// time, owner signals steered combinationally to the bus controller.
module busarb
  import busarb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_en,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_wt,
  input  logic        m1_en,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_wt,
  output logic        bus_en,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_wt,
  output logic [1:0]  gnt
);

  state_t state, state_nxt;
  logic   last, last_nxt;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_en && (!m1_en || last == M_DMA)) begin
          state_nxt = OWN0;
          last_nxt  = M_CPU;
        end else if (m1_en) begin
          state_nxt = OWN1;
          last_nxt  = M_DMA;
        end
      end
      // bus_en follows the owner's en, so "!en || !bus_wt" covers both the
      // completed transfer and the abandoned request.
      OWN0:    if (!m0_en || !bus_wt) state_nxt = IDLE;
      OWN1:    if (!m1_en || !bus_wt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= M_DMA;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      gnt   <= gnt_of(state_nxt);
    end
  end

  always_comb begin
    bus_en    = 1'b0;
    bus_wr    = 1'b0;
    bus_size  = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    m0_wt     = 1'b1;
    m1_wt     = 1'b1;
    case (state)
      OWN0: begin
        bus_en    = m0_en;
        bus_wr    = m0_wr;
        bus_size  = m0_size;
        bus_addr  = m0_addr;
        bus_wdata = m0_wdata;
        m0_wt     = bus_wt;
      end
      OWN1: begin
        bus_en    = m1_en;
        bus_wr    = m1_wr;
        bus_size  = m1_size;
        bus_addr  = m1_addr;
        bus_wdata = m1_wdata;
        m1_wt     = bus_wt;
      end
      default: ;
    endcase
  end

  assign m0_rdata = bus_rdata;
  assign m1_rdata = bus_rdata;

endmodule

// File: tb/tb_busarb.sv
// Directed bench for busarb: master/bus models plus a completion scoreboard.
module tb_busarb;

  localparam logic [31:0] K = 32'hA5A5_5A5A;

  typedef struct packed {
    logic        id;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_en, m0_wr, m1_en, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_wt, m1_wt;
  logic        bus_en, bus_wr, bus_wt;
  logic [1:0]  bus_size, gnt;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  wait_n   = 0;
  bit  abort0   = 1'b0;
  bit  gap_pend = 1'b0;
  logic [7:0] cnt;

  txn_t q0[$], q1[$], exp_q[$];

  always #5 clk = ~clk;

  busarb dut (
    .clk(clk), .reset_n(reset_n),
    .m0_en(m0_en), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_wt(m0_wt),
    .m1_en(m1_en), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_wt(m1_wt),
    .bus_en(bus_en), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_wt(bus_wt), .gnt(gnt)
  );

  // Bus controller model: wait_n wait cycles per transfer, address-derived read data.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)              cnt <= '0;
    else if (bus_en && bus_wt) cnt <= cnt + 8'd1;
    else                       cnt <= '0;
  end
  assign bus_wt    = !(bus_en && (int'(cnt) >= wait_n));
  assign bus_rdata = bus_addr ^ K;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic req(input logic id, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit to_master, input bit to_sb);
    txn_t t;
    t.id = id; t.wr = wr; t.size = {wr, id}; t.addr = addr; t.wdata = wdata;
    if (to_master) begin
      if (id) q1.push_back(t);
      else    q0.push_back(t);
    end
    if (to_sb) exp_q.push_back(t);
  endtask

  task automatic wait_gnt(input logic [1:0] g, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (gnt === g);
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_empty(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !m0_en && !m1_en;
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic score(input logic id);
    txn_t e;
    check("sb_occupancy", {31'd0, exp_q.size() > 0}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("done_master", {31'd0, id}, {31'd0, e.id});
      check("done_addr", bus_addr, e.addr);
      check("done_wr", {31'd0, bus_wr}, {31'd0, e.wr});
      check("done_size", {30'd0, bus_size}, {30'd0, e.size});
      check("done_rdata", id ? m1_rdata : m0_rdata, e.addr ^ K);
      if (e.wr) check("done_wdata", bus_wdata, e.wdata);
    end
  endtask

  // Completion monitor: every transfer must match the scoreboard and be followed by IDLE.
  always @(negedge clk) begin
    if (gap_pend) check("idle_after_done", {30'd0, gnt}, 32'd0);
    gap_pend = 1'b0;
    if (m0_en && !m0_wt) begin
      score(1'b0);
      gap_pend = 1'b1;
    end else if (m1_en && !m1_wt) begin
      score(1'b1);
      gap_pend = 1'b1;
    end
  end

  initial begin : master0
    txn_t t;
    bit   d;
    m0_en = 1'b0; m0_wr = 1'b0; m0_size = '0; m0_addr = '0; m0_wdata = '0;
    forever begin
      @(negedge clk);
      d = m0_en && !m0_wt;
      @(posedge clk);
      #1;
      if (m0_en && (d || abort0)) begin
        m0_en  = 1'b0;
        abort0 = 1'b0;
      end
      if (!m0_en && q0.size() > 0) begin
        t = q0.pop_front();
        m0_wr = t.wr; m0_size = t.size; m0_addr = t.addr; m0_wdata = t.wdata;
        m0_en = 1'b1;
      end
    end
  end

  initial begin : master1
    txn_t t;
    bit   d;
    m1_en = 1'b0; m1_wr = 1'b0; m1_size = '0; m1_addr = '0; m1_wdata = '0;
    forever begin
      @(negedge clk);
      d = m1_en && !m1_wt;
      @(posedge clk);
      #1;
      if (m1_en && d) m1_en = 1'b0;
      if (!m1_en && q1.size() > 0) begin
        t = q1.pop_front();
        m1_wr = t.wr; m1_size = t.size; m1_addr = t.addr; m1_wdata = t.wdata;
        m1_en = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [1:0] pat [4];
    pat[0] = 2'b01; pat[1] = 2'b00; pat[2] = 2'b10; pat[3] = 2'b00;

    // Reset state
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_bus_en", {31'd0, bus_en}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_m0_wt", {31'd0, m0_wt}, 32'd1);
    check("rst_m1_wt", {31'd0, m1_wt}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single m0 read, two wait cycles
    wait_n = 2;
    req(1'b0, 1'b0, 32'h0000_0100, 32'd0, 1'b1, 1'b1);
    wait_gnt(2'b01, "r36_gnt");
    check("r36_wt_c1", {31'd0, m0_wt}, 32'd1);
    check("r36_bus_en", {31'd0, bus_en}, 32'd1);
    check("r36_bus_addr", bus_addr, 32'h0000_0100);
    check("r36_m1_wt", {31'd0, m1_wt}, 32'd1);
    @(negedge clk);
    check("r36_wt_c2", {31'd0, m0_wt}, 32'd1);
    @(negedge clk);
    check("r36_wt_c3", {31'd0, m0_wt}, 32'd0);
    check("r36_rdata", m0_rdata, 32'h0000_0100 ^ K);
    @(negedge clk);
    check("r36_idle_gnt", {30'd0, gnt}, 32'd0);
    check("r36_idle_en", {31'd0, bus_en}, 32'd0);
    wait_empty("r36_drain");

    // Simultaneous requests right after reset: m0 wins
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_n = 0;
    req(1'b0, 1'b0, 32'h0000_0200, 32'd0, 1'b1, 1'b1);
    req(1'b1, 1'b0, 32'h0000_0204, 32'd0, 1'b1, 1'b1);
    wait_gnt(2'b01, "r37_first");
    check("r37_m1_wait", {31'd0, m1_wt}, 32'd1);
    @(negedge clk);
    check("r37_gap", {30'd0, gnt}, 32'd0);
    @(negedge clk);
    check("r37_second", {30'd0, gnt}, 32'd2);
    wait_empty("r37_drain");

    // Continuous contention: strict alternation with one IDLE cycle between grants
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 1'b0, 32'h0000_1000 + 32'(i * 4), 32'd0, 1'b1, 1'b1);
      req(1'b1, 1'b1, 32'h0000_2000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b1, 1'b1);
    end
    wait_gnt(2'b01, "r38_start");
    for (int i = 0; i < 16; i++) begin
      check($sformatf("r38_seq%0d", i), {30'd0, gnt}, {30'd0, pat[i % 4]});
      @(negedge clk);
    end
    wait_empty("r38_drain");

    // m1 write with m0 arriving mid-transfer
    wait_n = 3;
    req(1'b1, 1'b1, 32'h3010_0000, 32'hDEAD_BEEF, 1'b1, 1'b1);
    wait_gnt(2'b10, "r39_gnt1");
    check("r39_wdata", bus_wdata, 32'hDEAD_BEEF);
    check("r39_addr", bus_addr, 32'h3010_0000);
    check("r39_wr", {31'd0, bus_wr}, 32'd1);
    req(1'b0, 1'b0, 32'h0000_0300, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    check("r39_m0_hold1", {31'd0, m0_wt}, 32'd1);
    @(negedge clk);
    check("r39_m0_hold2", {31'd0, m0_wt}, 32'd1);
    @(negedge clk);
    check("r39_m1_done", {31'd0, m1_wt}, 32'd0);
    check("r39_m0_hold3", {31'd0, m0_wt}, 32'd1);
    @(negedge clk);
    check("r39_gap", {30'd0, gnt}, 32'd0);
    @(negedge clk);
    check("r39_m0_next", {30'd0, gnt}, 32'd1);
    wait_empty("r39_drain");

    // Reset pulse during a stalled m1 transfer
    wait_n = 100;
    req(1'b1, 1'b0, 32'h0000_0040, 32'd0, 1'b1, 1'b0);
    wait_gnt(2'b10, "r40_gnt1");
    check("r40_bus_en_pre", {31'd0, bus_en}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("r40_bus_en", {31'd0, bus_en}, 32'd0);
    check("r40_gnt", {30'd0, gnt}, 32'd0);
    check("r40_m1_wt", {31'd0, m1_wt}, 32'd1);
    check("r40_bus_addr", bus_addr, 32'd0);
    wait_n = 0;
    req(1'b0, 1'b0, 32'h0000_0050, 32'd0, 1'b1, 1'b1);
    req(1'b1, 1'b0, 32'h0000_0040, 32'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_gnt(2'b01, "r40_m0_wins");
    check("r40_m1_waits", {31'd0, m1_wt}, 32'd1);
    wait_empty("r40_drain");

    // m0 abandons its request before completion
    wait_n = 5;
    req(1'b0, 1'b0, 32'h0000_0080, 32'd0, 1'b1, 1'b0);
    wait_gnt(2'b01, "r41_gnt0");
    abort0 = 1'b1;
    req(1'b1, 1'b0, 32'h0000_0090, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    check("r41_bus_en", {31'd0, bus_en}, 32'd0);
    check("r41_m1_wt", {31'd0, m1_wt}, 32'd1);
    @(negedge clk);
    check("r41_idle", {30'd0, gnt}, 32'd0);
    @(negedge clk);
    check("r41_m1_gnt", {30'd0, gnt}, 32'd2);
    wait_empty("r41_drain");

    check("final_sb_empty", exp_q.size(), 32'd0);
    check("final_q_empty", q0.size() + q1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/busarb.md
BUSARB -- requirements
Module: busarb

Interface
REQ-001 Parameters: none; master count fixed at 2 (m0 = CPU, m1 = DMA master); data width 32, address width 32.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 m0_en / m1_en  input  1  master requests a bus transfer; held until that master sees its wt low.
REQ-006 m0_wr / m1_wr  input  1  1 = write, 0 = read.
REQ-007 m0_size / m1_size  input  2  transfer size, passed through unchanged.
REQ-008 m0_addr / m1_addr  input  32  transfer byte address.
REQ-009 m0_wdata / m1_wdata  input  32  write data from master.
REQ-010 m0_rdata / m1_rdata  output  32  read data to master.
REQ-011 m0_wt / m1_wt  output  1  wait to master; transfer done in the cycle with en=1 and wt=0.
REQ-012 bus_en, bus_wr  output  1 each  request and direction to the bus controller.
REQ-013 bus_size  output  2  size to the bus controller.
REQ-014 bus_addr, bus_wdata  output  32 each  address and write data to the bus controller.
REQ-015 bus_rdata  input  32  read data from the bus controller.
REQ-016 bus_wt  input  1  wait from the bus controller.
REQ-017 gnt  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 = idle.

Function
REQ-018 State machine: IDLE, OWN0, OWN1; one register "last" (1 bit) = last master granted.
REQ-019 IDLE: at the clock edge, only m0_en -> OWN0; only m1_en -> OWN1; both -> grant the master not equal to last; neither -> stay IDLE.
REQ-020 Entering OWNx SHALL set last = x.
REQ-021 OWNx: bus_en/wr/size/addr/wdata SHALL equal mx_* combinationally; mx_wt = bus_wt.
REQ-022 OWNx: at the edge where bus_en=1 and bus_wt=0 (transfer complete) -> IDLE.
REQ-023 OWNx with mx_en deasserted (protocol violation) -> IDLE at the next edge; no bus transfer is counted.
REQ-024 Non-owner master (and both masters in IDLE) SHALL see wt=1.
REQ-025 IDLE: bus_en, bus_wr = 0; bus_size = 00; bus_addr, bus_wdata = 0.
REQ-026 m0_rdata and m1_rdata SHALL both equal bus_rdata at all times; a master uses it only in its own completion cycle.
REQ-027 Arbitration latency: a request in IDLE is granted at the next edge, so the earliest completion is 1 cycle after the request.
REQ-028 Each completion returns the bus to IDLE for at least one cycle, so back-to-back transfers alternate under contention.
REQ-029 gnt SHALL be a registered decode of state: OWN0 = 01, OWN1 = 10, IDLE = 00.
REQ-030 No combinational path from bus_wt to any bus_* output.

Reset
REQ-031 reset_n low SHALL immediately force: state = IDLE, last = 1 (m0 wins the first tie), gnt = 00, all bus_* outputs 0, m0_wt = m1_wt = 1.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer: bus_en drops asynchronously, and no completion is signalled to any master.
REQ-033 After reset_n deasserts, the first edge SHALL arbitrate per REQ-019.

Structure
REQ-034 The shared package SHALL hold the state encoding (IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10) and the master ID constants (M_CPU = 0, M_DMA = 1).
REQ-035 Single module with no sub-module: the state register, "last" register and output muxes are small enough to keep together.

Verification
REQ-036 Reset, then m0_en=1 read at 0x00000100, bus_wt low after 2 cycles -> gnt=01, m0_wt=1 for 2 cycles then 0, m0_rdata = bus_rdata, then IDLE.
REQ-037 m0_en and m1_en rise in the same cycle, right after reset -> m0 served first; m1 granted after 1 IDLE cycle; last=1 after m1 completes.
REQ-038 Both masters continuously request 4 transfers each with bus_wt=0 -> grant order m0, m1, m0, m1, ...; every grant is separated by exactly one IDLE cycle.
REQ-039 m1 write 0xDEADBEEF to 0x30100000 while m0 is idle, then m0 requests during the m1 transfer -> m0_wt stays 1 until m1 completes; bus_wdata = 0xDEADBEEF; m0 is granted next.
REQ-040 reset_n pulsed low during OWN1 with bus_wt=1 -> bus_en = 0 and gnt = 00 asynchronously, m1_wt = 1, and the next grant follows REQ-019 with last=1.
REQ-041 OWN0 with m0_en dropped before completion -> IDLE next edge, bus_en = 0, m1 request is then granted.
